// File: rtl/wave_seq_pkg.sv
// Shared types, reset-default segment table and duration helper for the wave sequencer.
package wave_seq_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic        DEF_LEVEL [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam int unsigned DEF_DUR   [0:3] = '{12, 5, 3, 10};

  // A zero duration still has to occupy one cycle so the pattern keeps moving.
  function automatic logic [31:0] eff_dur(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

  function automatic logic def_level(input int i);
    return (i < 4) ? DEF_LEVEL[i[1:0]] : 1'b0;
  endfunction

  function automatic int unsigned def_dur(input int i);
    return (i < 4) ? DEF_DUR[i[1:0]] : 32'd1;
  endfunction

endpackage

// File: rtl/wave_seq_table.sv
// Segment table: NSEG (level, duration) entries, reset defaults, one write and one async read port.
module wave_seq_table
  import wave_seq_pkg::*;
#(
  parameter  int NSEG  = 4,
  parameter  int DUR_W = 8,
  localparam int IDX_W = $clog2(NSEG)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic             wlevel,
  input  logic [DUR_W-1:0] wdur,
  input  logic [IDX_W-1:0] raddr,
  output logic             rlevel,
  output logic [DUR_W-1:0] rdur
);

  logic [NSEG-1:0]            level_q;
  logic [NSEG-1:0][DUR_W-1:0] dur_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSEG; i++) begin
        level_q[i] <= def_level(i);
        dur_q[i]   <= DUR_W'(def_dur(i));
      end
    end else if (we) begin
      level_q[waddr] <= wlevel;
      dur_q[waddr]   <= wdur;
    end
  end

  // Read sees the pre-edge contents, so a same-edge write never leaks into a load.
  assign rlevel = level_q[raddr];
  assign rdur   = dur_q[raddr];

endmodule

// File: rtl/wave_seq_ctrl.sv
// Table-driven waveform sequencer (one-shot / loop, stop, live reprogramming).
// Optional pass counter output enabled by WAVE_SEQ_CYCLE_COUNT_EN.
module wave_seq_ctrl
  import wave_seq_pkg::*;
#(
  parameter  int NSEG  = 4,
  parameter  int DUR_W = 8,
  localparam int IDX_W = $clog2(NSEG)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic             cfg_level,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [IDX_W-1:0] cfg_last,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic             wave_out,
  output logic             busy,
  output logic [IDX_W-1:0] seg_idx,
  output logic             done
`ifdef WAVE_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]      cycle_count
`endif
);

  state_e           state;
  logic             loop_q;
  logic [IDX_W-1:0] last_q, last_clamp, rd_addr;
  logic [DUR_W-1:0] cnt, rd_dur, rd_dur_eff;
  logic             rd_level;

  wave_seq_table #(.NSEG(NSEG), .DUR_W(DUR_W)) u_table (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wlevel (cfg_level),
    .wdur   (cfg_dur),
    .raddr  (rd_addr),
    .rlevel (rd_level),
    .rdur   (rd_dur)
  );

  // The single read port always points at the segment that would be loaded next.
  always_comb begin
    last_clamp = (int'(cfg_last) > NSEG - 1) ? IDX_W'(NSEG - 1) : cfg_last;
    rd_addr    = (state == RUN && seg_idx != last_q) ? seg_idx + IDX_W'(1) : '0;
    rd_dur_eff = DUR_W'(eff_dur(32'(rd_dur)));
  end

  assign busy = (state == RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      loop_q   <= 1'b0;
      last_q   <= '0;
      cnt      <= '0;
      seg_idx  <= '0;
      wave_out <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !stop) begin
          state    <= RUN;
          loop_q   <= loop;
          last_q   <= last_clamp;
          seg_idx  <= '0;
          cnt      <= rd_dur_eff;
          wave_out <= rd_level;
        end
        RUN: begin
          if (stop) begin
            state    <= IDLE;
            wave_out <= 1'b0;
            seg_idx  <= '0;
          end else if (cnt > DUR_W'(1)) begin
            cnt <= cnt - DUR_W'(1);
          end else if (seg_idx != last_q || loop_q) begin
            seg_idx  <= rd_addr;
            cnt      <= rd_dur_eff;
            wave_out <= rd_level;
          end else begin
            state    <= IDLE;
            wave_out <= 1'b0;
            seg_idx  <= '0;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WAVE_SEQ_CYCLE_COUNT_EN
  logic accept, pass_end;
  assign accept   = (state == IDLE) && start && !stop;
  assign pass_end = (state == RUN) && !stop && (cnt <= DUR_W'(1)) && (seg_idx == last_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      cycle_count <= '0;
    else if (accept)   cycle_count <= '0;
    else if (pass_end) cycle_count <= cycle_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Bench for wave_seq_ctrl: vector table, directed corner sequences and a queue-based reference model.
module tb_wave_seq_ctrl;
  localparam int NSEG = 4, DUR_W = 8, IDX_W = 2;

  logic clock = 1'b0, reset_n = 1'b0;
  logic cfg_we = 1'b0, cfg_level = 1'b0, loop = 1'b0, start = 1'b0, stop = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0, cfg_last = 2'd3;
  logic [DUR_W-1:0] cfg_dur = '0;
  logic wave_out, busy, done;
  logic [IDX_W-1:0] seg_idx;
`ifdef WAVE_SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  int checks = 0, errors = 0;

  wave_seq_ctrl #(.NSEG(NSEG), .DUR_W(DUR_W)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_level(cfg_level), .cfg_dur(cfg_dur), .cfg_last(cfg_last), .loop(loop),
    .start(start), .stop(stop), .wave_out(wave_out), .busy(busy),
    .seg_idx(seg_idx), .done(done)
`ifdef WAVE_SEQ_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference model: the pattern is a queue of per-cycle (segment, level) entries,
  // refilled one whole segment at a time from a snapshot of the model table.
  int mlev [4];
  int mdur [4];
  int q_seg[$];
  int q_lvl[$];
  bit m_busy, m_done, m_loop;
  int m_last, m_cc;

  function automatic void m_reset();
    mlev = '{0, 1, 0, 1};
    mdur = '{12, 5, 3, 10};
    q_seg.delete(); q_lvl.delete();
    m_busy = 0; m_done = 0; m_loop = 0; m_last = 0; m_cc = 0;
  endfunction

  function automatic void m_load(int s);
    int n;
    n = (mdur[s] == 0) ? 1 : mdur[s];
    for (int i = 0; i < n; i++) begin
      q_seg.push_back(s);
      q_lvl.push_back(mlev[s]);
    end
  endfunction

  function automatic void m_step(bit st, bit sp, bit we, int wa, int wl, int wd, bit lp, int la);
    int s;
    m_done = 0;
    if (m_busy) begin
      if (sp) begin
        m_busy = 0; q_seg.delete(); q_lvl.delete();
      end else begin
        s = q_seg.pop_front();
        void'(q_lvl.pop_front());
        if (q_seg.size() == 0) begin
          if (s < m_last) m_load(s + 1);
          else begin
            m_cc = (m_cc + 1) & 16'hffff;
            if (m_loop) m_load(0);
            else begin m_busy = 0; m_done = 1; end
          end
        end
      end
    end else if (st && !sp) begin
      m_loop = lp;
      m_last = (la > NSEG - 1) ? NSEG - 1 : la;
      m_cc = 0;
      m_load(0);
      m_busy = 1;
    end
    if (we) begin mlev[wa] = wl; mdur[wa] = wd; end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit st, sp, we, lp;
    int wa, wl, wd, la;
    st = start; sp = stop; we = cfg_we; lp = loop;
    wa = int'(cfg_addr); wl = int'(cfg_level); wd = int'(cfg_dur); la = int'(cfg_last);
    @(posedge clock); #1;
    m_step(st, sp, we, wa, wl, wd, lp, la);
    chk("model_wave", wave_out, m_busy ? q_lvl[0] : 0);
    chk("model_busy", busy, m_busy);
    chk("model_done", done, m_done);
    if (m_busy) chk("model_seg", seg_idx, q_seg[0]);
`ifdef WAVE_SEQ_CYCLE_COUNT_EN
    chk("model_cc", cycle_count, m_cc);
`endif
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wave", wave_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seg", seg_idx, 0);
    m_reset();
    start = 0; stop = 0; cfg_we = 0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int   reps;
    logic st, sp;
    logic w, b, d;
  } vec_t;

  vec_t vt [9];
  int   n, c1, c2, hi;
  logic wv [0:95];
  int   sv [0:95];

  initial begin
    vt[0] = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[5] = '{3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[7] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8] = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    m_reset();
    #2;
    chk("por_wave", wave_out, 0);
    chk("por_busy", busy, 0);
    chk("por_seg", seg_idx, 0);
    chk("por_done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // start+stop in idle, then the default one-shot pattern 12/5/3/10
    loop = 0; cfg_last = 3;
    foreach (vt[i]) begin
      for (int r = 0; r < vt[i].reps; r++) begin
        start = vt[i].st; stop = vt[i].sp;
        tick();
        chk($sformatf("vec%0d_wave", i), wave_out, vt[i].w);
        chk($sformatf("vec%0d_busy", i), busy, vt[i].b);
        chk($sformatf("vec%0d_done", i), done, vt[i].d);
      end
    end
    start = 0; stop = 0;

    // looping: three passes with a 30-cycle period and no done
    loop = 1; start = 1; tick(); start = 0;
    wv[0] = wave_out;
    c1 = int'(done);
    for (int k = 1; k <= 90; k++) begin
      tick();
      wv[k] = wave_out;
      c1 += int'(done);
    end
    chk("loop_no_done", c1, 0);
    for (int p = 0; p < 3; p++) begin
      hi = 0;
      for (int k = 0; k < 30; k++) hi += int'(wv[p*30 + k]);
      chk($sformatf("loop_pass%0d_high", p), hi, 15);
      chk($sformatf("loop_pass%0d_wrap", p), wv[p*30 + 29], 1);
      chk($sformatf("loop_pass%0d_first", p), wv[p*30 + 30], 0);
    end
`ifdef WAVE_SEQ_CYCLE_COUNT_EN
    chk("loop_cc3", cycle_count, 3);
`endif
    stop = 1; tick(); stop = 0;

    // stop in segment 1, then restart from segment 0
    loop = 0; start = 1; tick(); start = 0;
    for (int k = 0; k < 14; k++) tick();
    chk("pre_stop_seg", seg_idx, 1);
    stop = 1; start = 1; tick(); stop = 0; start = 0;
    chk("stop_wave", wave_out, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    c1 = 0;
    for (int k = 0; k < 5; k++) begin tick(); c1 += int'(done) + int'(busy); end
    chk("stop_quiet", c1, 0);
    start = 1; tick(); start = 0;
    chk("restart_seg", seg_idx, 0);
    chk("restart_busy", busy, 1);
    stop = 1; tick(); stop = 0;

    // zero-duration entry 2 at level 1, last=2: 12+5+1 cycles
    cfg_we = 1; cfg_addr = 2; cfg_level = 1; cfg_dur = 0; tick(); cfg_we = 0;
    cfg_last = 2; loop = 0; start = 1; tick(); start = 0;
    n = 0;
    do begin tick(); n++; end while (!done && n < 200);
    chk("zero_dur_total", n, 18);

    // reprogram entry 1 while it plays: current pass keeps 5, next pass gets 20
    do_reset();
    cfg_last = 3; loop = 1; start = 1; tick(); start = 0;
    sv[0] = int'(seg_idx); wv[0] = wave_out;
    for (int k = 1; k < 80; k++) begin
      if (k == 14) begin cfg_we = 1; cfg_addr = 1; cfg_level = 0; cfg_dur = 20; end
      tick();
      cfg_we = 0;
      sv[k] = int'(seg_idx); wv[k] = wave_out;
    end
    c1 = 0; c2 = 0; hi = 0;
    for (int k = 0; k < 30; k++) if (sv[k] == 1) c1++;
    for (int k = 30; k < 75; k++) if (sv[k] == 1) begin c2++; hi += int'(wv[k]); end
    chk("rewrite_cur_len", c1, 5);
    chk("rewrite_next_len", c2, 20);
    chk("rewrite_next_lvl", hi, 0);
    stop = 1; tick(); stop = 0;

    // async reset mid-run restores the default table
    cfg_last = 3; loop = 0; start = 1; tick(); start = 0;
    for (int k = 0; k < 20; k++) tick();
    do_reset();
    start = 1; tick(); start = 0;
    n = 0;
    do begin tick(); n++; end while (!done && n < 200);
    chk("post_reset_total", n, 30);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      loop  = $urandom_range(0, 1);
      cfg_last = IDX_W'($urandom_range(0, 3));
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_addr = IDX_W'($urandom_range(0, 3));
      cfg_level = $urandom_range(0, 1);
      cfg_dur = DUR_W'($urandom_range(0, 6));
      tick();
    end
    start = 0; stop = 0; cfg_we = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
